// File: rtl/wb_mem_arbiter.sv
// Three-master round-robin Wishbone B3 arbiter in front of a single RAM slave.
// Optional bus watchdog with ABORT state is enabled by defining WB_ARB_WATCHDOG_EN.
module wb_mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   input  logic [3*AW-1:0]       m_adr_i,
   input  logic [3*DW-1:0]       m_dat_i,
   input  logic [3*(DW/8)-1:0]   m_sel_i,
   input  logic [2:0]            m_we_i,
   input  logic [2:0]            m_cyc_i,
   input  logic [2:0]            m_stb_i,
   input  logic [8:0]            m_cti_i,
   input  logic [5:0]            m_bte_i,
   output logic [3*DW-1:0]       m_dat_o,
   output logic [2:0]            m_ack_o,
   output logic [2:0]            m_err_o,
   output logic [2:0]            m_rty_o,
   output logic [AW-1:0]         s_adr_o,
   output logic [DW-1:0]         s_dat_o,
   output logic [DW/8-1:0]       s_sel_o,
   output logic                  s_we_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic [2:0]            s_cti_o,
   output logic [1:0]            s_bte_o,
   input  logic [DW-1:0]         s_dat_i,
   input  logic                  s_ack_i,
   input  logic                  s_err_i,
   input  logic                  s_rty_i,
   output logic [2:0]            grant_o
);

   localparam int SW = DW / 8;

`ifdef WB_ARB_WATCHDOG_EN
   typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
`else
   typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

   state_t      state_reg, state_next;
   logic [2:0]  grant_reg, grant_next;
   logic [1:0]  gidx_reg, gidx_next;
   logic [1:0]  last_reg, last_next;
   logic        busy;
   logic        wd_hit;

   logic [AW-1:0] adr_arr [3];
   logic [DW-1:0] dat_arr [3];
   logic [SW-1:0] sel_arr [3];
   logic [2:0]    cti_arr [3];
   logic [1:0]    bte_arr [3];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slice
         assign adr_arr[gi] = m_adr_i[gi*AW +: AW];
         assign dat_arr[gi] = m_dat_i[gi*DW +: DW];
         assign sel_arr[gi] = m_sel_i[gi*SW +: SW];
         assign cti_arr[gi] = m_cti_i[gi*3 +: 3];
         assign bte_arr[gi] = m_bte_i[gi*2 +: 2];
         assign m_dat_o[gi*DW +: DW] = busy ? s_dat_i : '0;
      end
   endgenerate

   // Round-robin search order starts just after the last released master.
   logic [1:0] ord [3];
   logic [1:0] pick;
   logic       found;

   always_comb begin
      case (last_reg)
         2'd0:    ord = '{2'd1, 2'd2, 2'd0};
         2'd1:    ord = '{2'd2, 2'd0, 2'd1};
         default: ord = '{2'd0, 2'd1, 2'd2};
      endcase
      pick  = 2'd0;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!found && m_cyc_i[ord[k]]) begin
            found = 1'b1;
            pick  = ord[k];
         end
      end
   end

   assign busy = (state_reg == BUSY);

`ifdef WB_ARB_WATCHDOG_EN
   logic [15:0] cnt_reg, cnt_next;
   logic        stalled;
   logic        resp;

   assign resp    = s_ack_i | s_err_i | s_rty_i;
   assign stalled = busy & s_stb_o & ~resp;
   assign wd_hit  = stalled && (cnt_reg == 16'(TIMEOUT - 1));

   always_comb begin
      cnt_next = cnt_reg;
      if (state_next != BUSY || resp)
         cnt_next = '0;
      else if (stalled)
         cnt_next = cnt_reg + 16'd1;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end
`else
   localparam logic [15:0] TO_V = 16'(TIMEOUT);
   logic unused_timeout;

   // Keeps TIMEOUT referenced in builds without the watchdog.
   assign unused_timeout = ^TO_V;
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      gidx_next  = gidx_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               grant_next = 3'b001 << pick;
               gidx_next  = pick;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (!m_cyc_i[gidx_reg]) begin
               state_next = IDLE;
               grant_next = 3'b000;
               last_next  = gidx_reg;
            end else if (wd_hit) begin
`ifdef WB_ARB_WATCHDOG_EN
               state_next = ABORT;
`endif
            end
         end
`ifdef WB_ARB_WATCHDOG_EN
         ABORT: begin
            if (!m_cyc_i[gidx_reg]) begin
               state_next = IDLE;
               grant_next = 3'b000;
               last_next  = gidx_reg;
            end
         end
`endif
         default: begin
            state_next = IDLE;
            grant_next = 3'b000;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_reg <= IDLE;
         grant_reg <= 3'b000;
         gidx_reg  <= 2'd0;
         last_reg  <= 2'd2;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         gidx_reg  <= gidx_next;
         last_reg  <= last_next;
      end
   end

   assign grant_o = grant_reg;

   assign s_cyc_o = busy & m_cyc_i[gidx_reg];
   assign s_stb_o = busy & m_stb_i[gidx_reg];
   assign s_we_o  = busy & m_we_i[gidx_reg];
   assign s_adr_o = busy ? adr_arr[gidx_reg] : '0;
   assign s_dat_o = busy ? dat_arr[gidx_reg] : '0;
   assign s_sel_o = busy ? sel_arr[gidx_reg] : '0;
   assign s_cti_o = busy ? cti_arr[gidx_reg] : '0;
   assign s_bte_o = busy ? bte_arr[gidx_reg] : '0;

   assign m_ack_o = busy ? (grant_reg & {3{s_ack_i}}) : 3'b000;
   assign m_err_o = busy ? (grant_reg & {3{s_err_i | wd_hit}}) : 3'b000;
   assign m_rty_o = busy ? (grant_reg & {3{s_rty_i}}) : 3'b000;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed scoreboard bench for wb_mem_arbiter: expectations are queued as stimulus
// is driven and popped against DUT outputs; watchdog steps run when WB_ARB_WATCHDOG_EN is set.
module tb_wb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [3*AW-1:0] m_adr_i;
   logic [3*DW-1:0] m_dat_i;
   logic [11:0]     m_sel_i;
   logic [2:0]      m_we_i, m_cyc_i, m_stb_i;
   logic [8:0]      m_cti_i;
   logic [5:0]      m_bte_i;
   logic [3*DW-1:0] m_dat_o;
   logic [2:0]      m_ack_o, m_err_o, m_rty_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [3:0]      s_sel_o;
   logic            s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]      s_cti_o;
   logic [1:0]      s_bte_o;
   logic [DW-1:0]   s_dat_i;
   logic            s_ack_i, s_err_i, s_rty_i;
   logic [2:0]      grant_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [95:0] val;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .grant_o(grant_o)
   );

   task automatic push_exp(input string tag, input logic [95:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [95:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
         $display("check %s observed=%h", e.tag, obs);
      end
   endtask

   task automatic expect_now(input string tag, input logic [95:0] exp_v, input logic [95:0] obs);
      push_exp(tag, exp_v);
      check(obs);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic [2:0] cti);
      m_cyc_i[k] = cyc;
      m_stb_i[k] = stb;
      m_we_i[k]  = we;
      m_adr_i[k*AW +: AW] = adr;
      m_dat_i[k*DW +: DW] = dat;
      m_sel_i[k*4 +: 4]   = sel;
      m_cti_i[k*3 +: 3]   = cti;
      m_bte_i[k*2 +: 2]   = 2'b00;
   endtask

   initial begin
      rst_n = 1'b0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
      m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
      #3;
      expect_now("rst_grant", 96'h0, 96'(grant_o));
      expect_now("rst_s_cyc", 96'h0, 96'(s_cyc_o));
      expect_now("rst_ack",   96'h0, 96'(m_ack_o));

      // Release reset and raise all three requests in the same cycle.
      step();
      rst_n = 1'b1;
      #1;
      expect_now("rst_release_no_edge", 96'h0, 96'(grant_o));
      set_m(0, 1, 1, 0, 32'h10, 32'h0, 4'hF, 3'b000);
      set_m(1, 1, 1, 0, 32'h20, 32'h0, 4'hF, 3'b000);
      set_m(2, 1, 1, 0, 32'h30, 32'h0, 4'hF, 3'b000);
      #1;
      expect_now("grant_before_edge", 96'h0, 96'(grant_o));
      push_exp("rr_first_grant", 96'b001);
      push_exp("rr_first_s_cyc", 96'h1);
      push_exp("rr_first_s_adr", 96'h10);
      step();
      check(96'(grant_o));
      check(96'(s_cyc_o));
      check(96'(s_adr_o));

      set_m(0, 0, 0, 0, 32'h10, 32'h0, 4'hF, 3'b000);
      #1;
      expect_now("release_s_cyc_same_cycle", 96'h0, 96'(s_cyc_o));
      step();
      expect_now("idle_gap_grant", 96'h0, 96'(grant_o));
      step();
      expect_now("rr_second_grant", 96'b010, 96'(grant_o));
      expect_now("rr_second_s_adr", 96'h20, 96'(s_adr_o));
      set_m(1, 0, 0, 0, 32'h20, 32'h0, 4'hF, 3'b000);
      step();
      expect_now("idle_gap2_grant", 96'h0, 96'(grant_o));
      step();
      expect_now("rr_third_grant", 96'b100, 96'(grant_o));

      // Master 2 burst with master 1 competing; one stb-low gap mid-burst.
      set_m(1, 1, 1, 0, 32'h24, 32'h0, 4'hF, 3'b000);
      for (int i = 0; i < 8; i++) begin
         set_m(2, 1, 1, 0, 32'h100 + 32'(4*i), 32'h0, 4'hF, (i == 7) ? 3'b111 : 3'b010);
         s_ack_i = 1'b1;
         s_dat_i = 32'hA0 + 32'(i);
         #1;
         expect_now($sformatf("burst_ack_b%0d", i), 96'b100, 96'(m_ack_o));
         expect_now($sformatf("burst_adr_b%0d", i), 96'(32'h100 + 32'(4*i)), 96'(s_adr_o));
         expect_now($sformatf("burst_dat_m1_b%0d", i), 96'(32'hA0 + 32'(i)), 96'(m_dat_o[DW +: DW]));
         step();
         if (i == 3) begin
            m_stb_i[2] = 1'b0;
            s_ack_i = 1'b0;
            #1;
            expect_now("burst_gap_grant", 96'b100, 96'(grant_o));
            expect_now("burst_gap_s_stb", 96'h0, 96'(s_stb_o));
            step();
         end
      end
      s_ack_i = 1'b0;
      set_m(2, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
      #1;
      expect_now("burst_release_s_cyc", 96'h0, 96'(s_cyc_o));
      step();
      expect_now("burst_idle_grant", 96'h0, 96'(grant_o));
      step();
      expect_now("after_burst_grant", 96'b010, 96'(grant_o));

      // Master 1 single write mirrored onto the slave port.
      set_m(1, 1, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 3'b000);
      #1;
      expect_now("wr_s_adr", 96'h2000, 96'(s_adr_o));
      expect_now("wr_s_dat", 96'hDEADBEEF, 96'(s_dat_o));
      expect_now("wr_s_sel", 96'hF, 96'(s_sel_o));
      expect_now("wr_s_we",  96'h1, 96'(s_we_o));
      expect_now("wr_s_stb", 96'h1, 96'(s_stb_o));
      expect_now("wr_s_cti", 96'h0, 96'(s_cti_o));
      s_ack_i = 1'b1;
      #1;
      expect_now("wr_ack_route", 96'b010, 96'(m_ack_o));
      expect_now("wr_err_none",  96'b000, 96'(m_err_o));
      step();
      s_ack_i = 1'b0;
      set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
      step();
      expect_now("wr_release_grant", 96'h0, 96'(grant_o));

      // Master 0 read terminated with an error.
      set_m(0, 1, 1, 0, 32'h40, 32'h0, 4'hF, 3'b000);
      step();
      expect_now("err_grant", 96'b001, 96'(grant_o));
      s_err_i = 1'b1;
      #1;
      expect_now("err_route", 96'b001, 96'(m_err_o));
      expect_now("err_no_ack", 96'b000, 96'(m_ack_o));
      step();
      s_err_i = 1'b0;
      #1;
      expect_now("err_grant_kept", 96'b001, 96'(grant_o));
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
      step();
      expect_now("err_release_grant", 96'h0, 96'(grant_o));

      // Slave responses while idle never reach a master.
      s_ack_i = 1'b1;
      s_err_i = 1'b1;
      #1;
      expect_now("idle_ack_ignored", 96'b000, 96'(m_ack_o));
      expect_now("idle_err_ignored", 96'b000, 96'(m_err_o));
      expect_now("idle_s_cyc", 96'h0, 96'(s_cyc_o));
      s_ack_i = 1'b0;
      s_err_i = 1'b0;

`ifdef WB_ARB_WATCHDOG_EN
      // Stalled slave: error pulse on the 4th stalled cycle, then ABORT.
      set_m(0, 1, 1, 0, 32'h50, 32'h0, 4'hF, 3'b000);
      step();
      expect_now("wd_grant", 96'b001, 96'(grant_o));
      for (int i = 1; i <= 4; i++) begin
         #1;
         expect_now($sformatf("wd_err_c%0d", i), (i == 4) ? 96'b001 : 96'b000, 96'(m_err_o));
         step();
      end
      expect_now("wd_abort_s_cyc", 96'h0, 96'(s_cyc_o));
      expect_now("wd_abort_err", 96'b000, 96'(m_err_o));
      expect_now("wd_abort_grant", 96'b001, 96'(grant_o));
      step();
      expect_now("wd_abort_hold", 96'b001, 96'(grant_o));
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
      step();
      expect_now("wd_release_grant", 96'h0, 96'(grant_o));
`endif

      // Asynchronous reset in the middle of a master 2 burst.
      set_m(2, 1, 1, 0, 32'h300, 32'h0, 4'hF, 3'b010);
      step();
      expect_now("rst_burst_grant", 96'b100, 96'(grant_o));
      s_ack_i = 1'b1;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      expect_now("async_rst_s_cyc", 96'h0, 96'(s_cyc_o));
      expect_now("async_rst_grant", 96'h0, 96'(grant_o));
      expect_now("async_rst_ack", 96'h0, 96'(m_ack_o));
      s_ack_i = 1'b0;
      set_m(0, 1, 1, 0, 32'h60, 32'h0, 4'hF, 3'b000);
      set_m(1, 1, 1, 0, 32'h64, 32'h0, 4'hF, 3'b000);
      step();
      rst_n = 1'b1;
      #1;
      expect_now("post_rst_no_edge", 96'h0, 96'(grant_o));
      step();
      expect_now("post_rst_grant", 96'b001, 96'(grant_o));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      failures++;
      $display("FAIL timeout checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
